repeated_sub_divider: RTL and testbench

- Unsigned integer divider using repeated subtraction. It is a controller FSM driving a datapath.
- Operands arrive serially on one shared input bus: dividend first, divisor on the next cycle.
- The quotient is presented on Pout with a done flag.
- Standalone arithmetic block, used where throughput is irrelevant and area must be minimal.

---
 rtl/repeated_sub_divider_pkg.sv | 21 ++
 rtl/repeated_sub_divider_datapath.sv | 96 +++++++++
 rtl/repeated_sub_divider.sv | 132 +++++++++++++
 tb/tb_repeated_sub_divider.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/repeated_sub_divider_pkg.sv
// -----------------------------------------------------------------------------
// repeated_sub_divider_pkg
// Shared definitions for the repeated-subtraction divider: controller state
// encoding, default operand width and the quotient reported on divide-by-zero.
// -----------------------------------------------------------------------------
package repeated_sub_divider_pkg;

   localparam int WIDTH_DEF = 16;

   // Quotient returned when the divisor is zero (all ones at default width)
   localparam logic [WIDTH_DEF-1:0] DIV0_QUOTIENT = {WIDTH_DEF{1'b1}};

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_A  = 3'd1,
      LOAD_B  = 3'd2,
      COMPUTE = 3'd3,
      DONE    = 3'd4
   } state_e;

endpackage : repeated_sub_divider_pkg

// File: rtl/repeated_sub_divider_datapath.sv
// -----------------------------------------------------------------------------
// rsd_datapath
// Holds the dividend/remainder register A, divisor register B and quotient
// register P, together with the A>=B comparator, the A-B subtractor and the
// B==0 detector. All register updates are commanded by strobes from the FSM.
//
// Optional macro DIV_REMAINDER_OUT_EN adds rem_o (= register A).
//
// Ports:
//   clock_i     rising-edge clock
//   reset_n_i   synchronous active-low reset
//   data_i      shared operand bus
//   load_a_i    capture dividend into A and clear P
//   load_b_i    capture divisor into B
//   sub_en_i    A <= A - B, P <= P + 1
//   div0_set_i  P <= all ones (divide-by-zero result)
//   a_ge_b_o    comparator result A >= B
//   b_zero_o    B == 0
//   p_o         quotient register
//   rem_o       remainder register (only with DIV_REMAINDER_OUT_EN)
// -----------------------------------------------------------------------------
module rsd_datapath
   import repeated_sub_divider_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clock_i,
   input  logic             reset_n_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             load_a_i,
   input  logic             load_b_i,
   input  logic             sub_en_i,
   input  logic             div0_set_i,
   output logic             a_ge_b_o,
   output logic             b_zero_o,
`ifdef DIV_REMAINDER_OUT_EN
   output logic [WIDTH-1:0] rem_o,
`endif
   output logic [WIDTH-1:0] p_o
);

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] p_q;

   // Subtract is only ever enabled when A >= B, so it cannot underflow
   assign a_ge_b_o = (a_q >= b_q);
   assign b_zero_o = (b_q == {WIDTH{1'b0}});
   assign p_o      = p_q;
`ifdef DIV_REMAINDER_OUT_EN
   assign rem_o    = a_q;
`endif

   // A register: dividend capture, then running remainder
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         a_q <= {WIDTH{1'b0}};
      end else if (load_a_i) begin
         a_q <= data_i;
      end else if (sub_en_i) begin
         a_q <= a_q - b_q;
      end else begin
         a_q <= a_q;
      end
   end

   // B register: divisor capture
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         b_q <= {WIDTH{1'b0}};
      end else if (load_b_i) begin
         b_q <= data_i;
      end else begin
         b_q <= b_q;
      end
   end

   // P register: cleared on dividend load, counts successful subtractions
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         p_q <= {WIDTH{1'b0}};
      end else if (load_a_i) begin
         p_q <= {WIDTH{1'b0}};
      end else if (div0_set_i) begin
         p_q <= ALL_ONES;
      end else if (sub_en_i) begin
         p_q <= p_q + ONE;
      end else begin
         p_q <= p_q;
      end
   end

endmodule : rsd_datapath

// File: rtl/repeated_sub_divider.sv
// -----------------------------------------------------------------------------
// repeated_sub_divider
// Unsigned divider by repeated subtraction. Operands arrive serially on
// data_in (dividend, then divisor on the following cycle); the quotient is
// presented on Pout and done stays high while it is valid.
//
// Optional macro DIV_REMAINDER_OUT_EN adds output rem_out (remainder; equals
// the dividend on divide-by-zero).
//
// Ports:
//   clock    rising-edge clock
//   reset_n  synchronous active-low reset
//   start    begin a division (honoured in IDLE and DONE only)
//   data_in  operand bus
//   Pout     quotient
//   done     result valid
//   rem_out  remainder (only with DIV_REMAINDER_OUT_EN)
// -----------------------------------------------------------------------------
module repeated_sub_divider
   import repeated_sub_divider_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
`ifdef DIV_REMAINDER_OUT_EN
   output logic [WIDTH-1:0] rem_out,
`endif
   output logic [WIDTH-1:0] Pout,
   output logic             done
);

   state_e state_q;
   state_e state_d;
   logic   done_q;

   logic load_a_s;
   logic load_b_s;
   logic sub_en_s;
   logic div0_set_s;
   logic a_ge_b_s;
   logic b_zero_s;

   // State register
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // done is registered from the next state so it rises with entry to DONE
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         done_q <= 1'b0;
      end else begin
         done_q <= (state_d == DONE);
      end
   end

   // Next-state logic and datapath strobes
   always_comb begin
      state_d    = state_q;
      load_a_s   = 1'b0;
      load_b_s   = 1'b0;
      sub_en_s   = 1'b0;
      div0_set_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD_A;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD_A: begin
            load_a_s = 1'b1;
            state_d  = LOAD_B;
         end
         LOAD_B: begin
            load_b_s = 1'b1;
            state_d  = COMPUTE;
         end
         COMPUTE: begin
            // Zero divisor must be tested first: A >= 0 is always true
            if (b_zero_s) begin
               div0_set_s = 1'b1;
               state_d    = DONE;
            end else if (a_ge_b_s) begin
               sub_en_s = 1'b1;
               state_d  = COMPUTE;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (start) begin
               state_d = LOAD_A;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign done = done_q;

   rsd_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clock_i    (clock),
      .reset_n_i  (reset_n),
      .data_i     (data_in),
      .load_a_i   (load_a_s),
      .load_b_i   (load_b_s),
      .sub_en_i   (sub_en_s),
      .div0_set_i (div0_set_s),
      .a_ge_b_o   (a_ge_b_s),
      .b_zero_o   (b_zero_s),
`ifdef DIV_REMAINDER_OUT_EN
      .rem_o      (rem_out),
`endif
      .p_o        (Pout)
   );

endmodule : repeated_sub_divider

// File: tb/tb_repeated_sub_divider.sv
// -----------------------------------------------------------------------------
// tb_repeated_sub_divider
// Directed bench for repeated_sub_divider at WIDTH=16. Inputs change 1 time
// unit after each rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_repeated_sub_divider;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [15:0] data_in;
   logic [15:0] Pout;
   logic        done;
`ifdef DIV_REMAINDER_OUT_EN
   logic [15:0] rem_out;
`endif

   int checks   = 0;
   int failures = 0;

   repeated_sub_divider #(
      .WIDTH (16)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .data_in (data_in),
`ifdef DIV_REMAINDER_OUT_EN
      .rem_out (rem_out),
`endif
      .Pout    (Pout),
      .done    (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Full transaction: start edge, dividend edge, divisor edge, then wait for
   // done. exp_n is the number of COMPUTE edges (q+1) before done is seen.
   task automatic run_div(input string tag, input logic [15:0] dvd, input logic [15:0] dvs,
                          input int exp_n, input logic [15:0] exp_q,
                          input logic [15:0] exp_rem, input bit toggle_start);
      int n;
      start   = 1'b1;
      data_in = 16'd0;
      tick();                       // edge 0: -> LOAD_A
      check({tag, "_done_low"}, {31'd0, done}, 32'd0);
      start   = 1'b0;
      data_in = dvd;
      tick();                       // edge 1: A captured
      data_in = dvs;
      tick();                       // edge 2: B captured
      n = 0;
      while (done !== 1'b1 && n < 70000) begin
         if (toggle_start) begin
            start   = ~start;
            data_in = 16'($urandom);
         end
         tick();
         n++;
      end
      start = 1'b0;
      check({tag, "_latency"}, n, exp_n);
      check({tag, "_quot"}, {16'd0, Pout}, {16'd0, exp_q});
`ifdef DIV_REMAINDER_OUT_EN
      check({tag, "_rem"}, {16'd0, rem_out}, {16'd0, exp_rem});
`else
      if (exp_rem != 16'd0) begin
         // remainder is not observable in this build
      end
`endif
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      data_in = 16'd0;
      tick();
      tick();
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_pout", {16'd0, Pout}, 32'd0);
      reset_n = 1'b1;
      tick();
      tick();
      check("idle_pout", {16'd0, Pout}, 32'd0);
      check("idle_done", {31'd0, done}, 32'd0);

      // 28/4: done after edge 10, quotient 7
      run_div("d28_4", 16'd28, 16'd4, 8, 16'd7, 16'd0, 1'b0);
      data_in = 16'hABCD;
      tick();
      tick();
      tick();
      check("d28_4_hold_q", {16'd0, Pout}, 32'd7);
      check("d28_4_hold_d", {31'd0, done}, 32'd1);

      // 7/9: single COMPUTE cycle
      run_div("d7_9", 16'd7, 16'd9, 1, 16'd0, 16'd7, 1'b0);

      // 4/0: divide by zero
      run_div("d4_0", 16'd4, 16'd0, 1, 16'hFFFF, 16'd4, 1'b0);
      tick();
      tick();
      check("d4_0_hold", {16'd0, Pout}, 32'hFFFF);

      // 100/100 then a restart from DONE with 0/5
      run_div("d100_100", 16'd100, 16'd100, 2, 16'd1, 16'd0, 1'b0);
      run_div("d0_5", 16'd0, 16'd5, 1, 16'd0, 16'd0, 1'b0);

      // Reset in the middle of 1000/3
      start   = 1'b1;
      tick();
      start   = 1'b0;
      data_in = 16'd1000;
      tick();
      data_in = 16'd3;
      tick();
      for (int i = 0; i < 5; i++) tick();
      check("mid_busy", {31'd0, done}, 32'd0);
      reset_n = 1'b0;
      tick();
      check("mid_rst_done", {31'd0, done}, 32'd0);
      check("mid_rst_pout", {16'd0, Pout}, 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("post_rst_done", {31'd0, done}, 32'd0);
      check("post_rst_pout", {16'd0, Pout}, 32'd0);

      // start and data_in toggled during COMPUTE are ignored
      run_div("d20_3_tog", 16'd20, 16'd3, 7, 16'd6, 16'd2, 1'b1);

      // Worst case: 65535/1, done after edge 65538
      run_div("dmax_1", 16'hFFFF, 16'd1, 65536, 16'hFFFF, 16'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_repeated_sub_divider
